simplez_core: RTL and testbench
===============================

SIMPLEZ_CORE -- requirements
Module: simplez_core

Interface
REQ-001 SHALL have parameter AW, default 9, address width (CD field, CP, RA).
REQ-002 SHALL have parameter DW, default AW+3, data width; opcode = RI[DW-1:DW-3], CD = RI[AW-1:0].
REQ-003 SHALL have parameter RESET_PC, default 0, CP value after reset.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on the falling edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port run  in  1  1 = start new instructions; 0 = pause at instruction boundary.
REQ-007 SHALL have port cont  in  1  one-cycle pulse; leaves HALT state.
REQ-008 SHALL have port mem_addr  out  AW  memory address (RA).
REQ-009 SHALL have port mem_re  out  1  read strobe; mem_rdata valid on the cycle after it.
REQ-010 SHALL have port mem_we  out  1  write strobe, written at the falling edge ending the cycle.
REQ-011 SHALL have port mem_wdata  out  DW  write data (AC).
REQ-012 SHALL have port mem_rdata  in  DW  read data.
REQ-013 SHALL have ports acc  out  DW  (AC), pc  out  AW  (CP), halted  out  1  (state = HALT).

Function
REQ-014 SHALL implement states FETCH, DECODE, OPER, WB, HALT.
REQ-015 FETCH with run=1: mem_addr=CP, mem_re=1, CP<=CP+1 mod 2^AW, next DECODE; with run=0: no strobes, stay FETCH.
REQ-016 DECODE: RI<=mem_rdata; opcode decoded from mem_rdata in the same cycle.
REQ-017 Opcodes: 0 ST, 1 LD, 2 ADD, 3 BR, 4 BZ, 5 CLR, 6 DEC, 7 HALT.
REQ-018 DECODE, BR: CP<=CD; BZ: CP<=CD only if AC==0, else CP unchanged; CLR: AC<=0; DEC: AC<=AC-1 mod 2^DW; all next FETCH.
REQ-019 DECODE, HALT: next HALT; ST/LD/ADD: next OPER.
REQ-020 OPER: mem_addr=CD; ST: mem_we=1, mem_wdata=AC, next FETCH; LD/ADD: mem_re=1, next WB.
REQ-021 WB: LD: AC<=mem_rdata; ADD: AC<=AC+mem_rdata mod 2^DW, carry discarded; next FETCH.
REQ-022 Latency in cycles, FETCH to next FETCH: BR/BZ/CLR/DEC 2, ST 3, LD/ADD 4.
REQ-023 HALT: no strobes, CP/AC/RI frozen; cont=1 -> FETCH; otherwise stay.
REQ-024 mem_re and mem_we SHALL never both be 1 and SHALL be 0 outside the states above.
REQ-025 run=0 in DECODE/OPER/WB SHALL NOT stall the running instruction.
REQ-026 cont in any state other than HALT SHALL be ignored.
REQ-027 CP wrap: 2^AW-1 + 1 -> 0 without flag; DEC of 0 -> all ones.

Reset
REQ-028 rstn=0 SHALL asynchronously force state=FETCH, CP=RESET_PC, AC=0, RI=0, halted=0, mem_re=0, mem_we=0, mem_addr=RESET_PC.
REQ-029 Reset mid-instruction SHALL abort it; a pending ST SHALL NOT write.
REQ-030 After rstn rises, the first fetch SHALL occur in the first cycle with run=1.

Structure
REQ-031 Package simplez_pkg SHALL hold the opcode constants and the state encoding.
REQ-032 Sub-module simplez_seq SHALL hold the FSM and microorder decode; datapath (CP, RA, RI, AC) SHALL stay in simplez_core.
REQ-033 Memory SHALL be external; the core SHALL contain no storage array.

Verification (AW=9, DW=12, octal values)
REQ-034 mem[0]=1100, [1]=2101, [2]=0102, [3]=7000, [100]=5, [101]=7 -> mem[102]=14, halted=1 after 13 cycles, pc=4.
REQ-035 AC=0, mem[0]=4010 (BZ 10) -> pc=10; repeat with AC=3 -> pc=1.
REQ-036 CLR then DEC -> acc=7777; ADD of 0001 to 7777 -> acc=0000.
REQ-037 RESET_PC=777, mem[777]=5000 (CLR) -> next fetch address 000.
REQ-038 rstn low in OPER of ST -> mem_we never asserted, state=FETCH, acc=0.
REQ-039 HALT reached, cont pulse -> fetch from pc; run=0 at FETCH -> no mem_re until run=1.

Source files
------------

// File: rtl/simplez_pkg.sv
// Shared opcode and sequencer-state encodings for the Simplez accumulator core.
package simplez_pkg;

    localparam int unsigned OPC_W = 3;

    typedef enum logic [OPC_W-1:0] {
        OpSt   = 3'd0,
        OpLd   = 3'd1,
        OpAdd  = 3'd2,
        OpBr   = 3'd3,
        OpBz   = 3'd4,
        OpClr  = 3'd5,
        OpDec  = 3'd6,
        OpHalt = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StOper   = 3'd2,
        StWb     = 3'd3,
        StHalt   = 3'd4
    } state_e;

    // Instructions that need a memory operand cycle after decode.
    function automatic logic needs_oper(input opcode_e op);
        return (op == OpSt) || (op == OpLd) || (op == OpAdd);
    endfunction

endpackage

// File: rtl/simplez_seq.sv
// Control sequencer: FSM plus microorder decode. State advances on the falling clock edge.
module simplez_seq
    import simplez_pkg::*;
(
    input  logic    clk,
    input  logic    rstn,
    input  logic    run,
    input  logic    cont,
    input  opcode_e op_rd,
    input  opcode_e op_ri,
    input  logic    ac_zero,
    output logic    mem_re,
    output logic    mem_we,
    output logic    addr_cd,
    output logic    cp_inc,
    output logic    cp_load,
    output logic    ri_load,
    output logic    ac_clr,
    output logic    ac_dec,
    output logic    ac_load,
    output logic    ac_add,
    output logic    halted
);

    state_e state;
    state_e state_d;

    always_comb begin
        state_d = state;
        unique case (state)
            StFetch:  state_d = run ? StDecode : StFetch;
            StDecode: begin
                if (op_rd == OpHalt) begin
                    state_d = StHalt;
                end else if (needs_oper(op_rd)) begin
                    state_d = StOper;
                end else begin
                    state_d = StFetch;
                end
            end
            StOper:   state_d = (op_ri == OpSt) ? StFetch : StWb;
            StWb:     state_d = StFetch;
            StHalt:   state_d = cont ? StFetch : StHalt;
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= StFetch;
            halted <= 1'b0;
        end else begin
            state  <= state_d;
            halted <= (state_d == StHalt);
        end
    end

    // Strobes are gated by rstn so a reset in any cycle drops them immediately.
    always_comb begin
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        addr_cd = 1'b0;
        cp_inc  = 1'b0;
        cp_load = 1'b0;
        ri_load = 1'b0;
        ac_clr  = 1'b0;
        ac_dec  = 1'b0;
        ac_load = 1'b0;
        ac_add  = 1'b0;
        unique case (state)
            StFetch: begin
                mem_re = rstn & run;
                cp_inc = run;
            end
            StDecode: begin
                ri_load = 1'b1;
                cp_load = (op_rd == OpBr) || ((op_rd == OpBz) && ac_zero);
                ac_clr  = (op_rd == OpClr);
                ac_dec  = (op_rd == OpDec);
            end
            StOper: begin
                addr_cd = 1'b1;
                mem_we  = rstn & (op_ri == OpSt);
                mem_re  = rstn & (op_ri != OpSt);
            end
            StWb: begin
                ac_load = (op_ri == OpLd);
                ac_add  = (op_ri == OpAdd);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/simplez_core.sv
// Simplez accumulator machine: datapath (CP, RA, RI, AC) around the simplez_seq sequencer.
module simplez_core
    import simplez_pkg::*;
#(
    parameter int unsigned   AW       = 9,
    parameter int unsigned   DW       = AW + 3,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          run,
    input  logic          cont,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] acc,
    output logic [AW-1:0] pc,
    output logic          halted
);

    logic [AW-1:0] cp;
    logic [AW-1:0] ra;
    logic [DW-1:0] ri;
    logic [DW-1:0] ac;

    logic addr_cd, cp_inc, cp_load, ri_load;
    logic ac_clr, ac_dec, ac_load, ac_add;

    opcode_e op_rd;
    opcode_e op_ri;

    assign op_rd = opcode_e'(mem_rdata[DW-1:DW-OPC_W]);
    assign op_ri = opcode_e'(ri[DW-1:DW-OPC_W]);

    simplez_seq u_seq (
        .clk     (clk),
        .rstn    (rstn),
        .run     (run),
        .cont    (cont),
        .op_rd   (op_rd),
        .op_ri   (op_ri),
        .ac_zero (ac == '0),
        .mem_re  (mem_re),
        .mem_we  (mem_we),
        .addr_cd (addr_cd),
        .cp_inc  (cp_inc),
        .cp_load (cp_load),
        .ri_load (ri_load),
        .ac_clr  (ac_clr),
        .ac_dec  (ac_dec),
        .ac_load (ac_load),
        .ac_add  (ac_add),
        .halted  (halted)
    );

    // Operand cycles address CD from RI; every other cycle presents CP.
    assign ra        = addr_cd ? ri[AW-1:0] : cp;
    assign mem_addr  = ra;
    assign mem_wdata = ac;
    assign acc       = ac;
    assign pc        = cp;

    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            cp <= RESET_PC;
            ri <= '0;
            ac <= '0;
        end else begin
            if (cp_inc) begin
                cp <= cp + 1'b1;
            end else if (cp_load) begin
                cp <= mem_rdata[AW-1:0];
            end
            if (ri_load) begin
                ri <= mem_rdata;
            end
            if (ac_clr) begin
                ac <= '0;
            end else if (ac_dec) begin
                ac <= ac - 1'b1;
            end else if (ac_load) begin
                ac <= mem_rdata;
            end else if (ac_add) begin
                ac <= ac + mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_simplez_core.sv
// Directed bench for simplez_core: small programs with hand-computed results, plus reset cases.
module tb_simplez_core;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 12;

    logic          clk = 1'b1;
    logic          rstn = 1'b0;
    logic          run = 1'b0;
    logic          cont = 1'b0;
    logic [AW-1:0] mem_addr, mem_addr2;
    logic          mem_re, mem_we, mem_re2, mem_we2;
    logic [DW-1:0] mem_wdata, mem_wdata2;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] mem_rdata2 = '0;
    logic [DW-1:0] acc, acc2;
    logic [AW-1:0] pc, pc2;
    logic          halted, halted2;

    logic [DW-1:0] mem  [512];
    logic [DW-1:0] mem2 [512];

    int            n_checks = 0;
    int            n_errs = 0;
    int            we_cnt = 0;
    int            excl_bad = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    int            we_snap;

    always #5 clk = ~clk;

    simplez_core u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .run       (run),
        .cont      (cont),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .acc       (acc),
        .pc        (pc),
        .halted    (halted)
    );

    simplez_core #(.AW(AW), .DW(DW), .RESET_PC(9'o777)) u_dut2 (
        .clk       (clk),
        .rstn      (rstn),
        .run       (run),
        .cont      (1'b0),
        .mem_addr  (mem_addr2),
        .mem_re    (mem_re2),
        .mem_we    (mem_we2),
        .mem_wdata (mem_wdata2),
        .mem_rdata (mem_rdata2),
        .acc       (acc2),
        .pc        (pc2),
        .halted    (halted2)
    );

    // Memory models: reads return data in the following cycle; writes are only logged.
    always @(negedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_re2) mem_rdata2 <= mem2[mem_addr2];
        if (mem_we) begin
            we_cnt  <= we_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
        if (mem_re && mem_we) excl_bad <= excl_bad + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0o exp %0o", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic enter_reset();
        rstn = 1'b0;
        run  = 1'b0;
        cont = 1'b0;
        #1;
        for (int i = 0; i < 512; i++) begin
            mem[i]  = '0;
            mem2[i] = '0;
        end
    endtask

    initial begin
        // Reset state, with run high to show strobes stay low under reset.
        enter_reset();
        step(1);
        run = 1'b1;
        #1;
        check_eq("rst_acc", acc, 0);
        check_eq("rst_pc", pc, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_re", mem_re, 0);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_addr2", mem_addr2, 9'o777);

        // LD 100 / ADD 101 / ST 102 / HALT, with a CLR/HALT tail for the cont test.
        mem[0] = 12'o1100; mem[1] = 12'o2101; mem[2] = 12'o0102; mem[3] = 12'o7000;
        mem[4] = 12'o5000; mem[5] = 12'o7000;
        mem[9'o100] = 12'o0005; mem[9'o101] = 12'o0007;
        mem2[9'o777] = 12'o5000;
        rstn = 1'b1;
        #1;
        check_eq("wrap_fetch_re", mem_re2, 1);
        step(1);
        check_eq("wrap_pc", pc2, 0);
        step(1);
        check_eq("wrap_next_addr", mem_addr2, 0);
        check_eq("wrap_next_re", mem_re2, 1);
        step(10);
        check_eq("prog_not_yet_halted", halted, 0);
        check_eq("prog_st_write_cnt", we_cnt, 1);
        check_eq("prog_st_addr", wr_addr, 9'o102);
        check_eq("prog_st_data", wr_data, 12'o0014);
        step(1);
        check_eq("prog_halted", halted, 1);
        check_eq("prog_pc", pc, 4);
        check_eq("prog_acc", acc, 12'o0014);

        // HALT holds without cont; a cont pulse resumes at pc; run=0 pauses in FETCH.
        step(2);
        check_eq("halt_hold", halted, 1);
        check_eq("halt_pc", pc, 4);
        check_eq("halt_no_re", mem_re, 0);
        cont = 1'b1;
        step(1);
        cont = 1'b0;
        check_eq("cont_halted", halted, 0);
        check_eq("cont_re", mem_re, 1);
        check_eq("cont_addr", mem_addr, 4);
        run = 1'b0;
        #1;
        check_eq("pause_re", mem_re, 0);
        step(3);
        check_eq("pause_re_hold", mem_re, 0);
        check_eq("pause_pc", pc, 4);
        run = 1'b1;
        #1;
        check_eq("resume_re", mem_re, 1);
        step(2);
        check_eq("clr_acc", acc, 0);
        check_eq("clr_pc", pc, 5);
        step(2);
        check_eq("halt2", halted, 1);
        check_eq("halt2_pc", pc, 6);

        // BZ taken with AC=0.
        enter_reset();
        mem[0] = 12'o4010;
        step(1);
        rstn = 1'b1;
        run  = 1'b1;
        step(2);
        check_eq("bz_taken_pc", pc, 9'o010);
        check_eq("bz_taken_addr", mem_addr, 9'o010);

        // LD 3, BZ not taken, BR 30, CLR, DEC, ADD 0001, HALT.
        enter_reset();
        mem[0] = 12'o1020; mem[1] = 12'o4010; mem[2] = 12'o3030;
        mem[9'o020] = 12'o0003;
        mem[9'o030] = 12'o5000; mem[9'o031] = 12'o6000; mem[9'o032] = 12'o2040;
        mem[9'o033] = 12'o7000; mem[9'o040] = 12'o0001;
        step(1);
        rstn = 1'b1;
        run  = 1'b1;
        step(6);
        check_eq("bz_not_taken_pc", pc, 2);
        check_eq("ld_acc", acc, 3);
        step(2);
        check_eq("br_pc", pc, 9'o030);
        step(2);
        check_eq("clr_acc2", acc, 0);
        step(2);
        check_eq("dec_wrap_acc", acc, 12'o7777);
        step(4);
        check_eq("add_wrap_acc", acc, 0);
        check_eq("add_pc", pc, 9'o033);
        step(2);
        check_eq("halt3", halted, 1);

        // Reset asserted in the OPER cycle of a ST must abort the write.
        enter_reset();
        mem[0] = 12'o1020; mem[1] = 12'o0050; mem[9'o020] = 12'o0003;
        step(1);
        rstn = 1'b1;
        run  = 1'b1;
        step(6);
        we_snap = we_cnt;
        rstn = 1'b0;
        #1;
        check_eq("abort_we", mem_we, 0);
        check_eq("abort_acc", acc, 0);
        check_eq("abort_pc", pc, 0);
        step(1);
        check_eq("abort_no_write", we_cnt, we_snap);
        rstn = 1'b1;
        #1;
        check_eq("abort_fetch_re", mem_re, 1);
        check_eq("abort_fetch_addr", mem_addr, 0);
        step(1);
        check_eq("re_we_exclusive", excl_bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
